// File: rtl/sram_pingpong_ctrl_if.sv
// Request/response bundle for the ping-pong SRAM controller.
// Capture writes, display reads and the frame-boundary bank swap.
interface sram_pingpong_ctrl_if #(
  parameter int AW = 20,
  parameter int DW = 16
);
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          swap_req;
  logic          swap_done;
  logic          bank_sel;

  modport master (
    output wr_req, wr_addr, wr_data,
    output rd_req, rd_addr, swap_req,
    input  wr_ack, rd_data, rd_valid,
    input  swap_done, bank_sel
  );

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr, swap_req,
    output wr_ack, rd_data, rd_valid,
    output swap_done, bank_sel
  );
endinterface

// File: rtl/sram_pingpong_ctrl.sv
// Ping-pong controller for two async SRAM banks: the write channel
// owns bank bank_sel, the read channel owns the other bank.
module sram_pingpong_ctrl #(
  parameter int AW       = 20,
  parameter int DW       = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  sram_pingpong_ctrl_if.slave bus,
  output logic [2*AW-1:0] sram_ab,
  inout  wire  [2*DW-1:0] sram_db,
  output logic [1:0]      sram_ce,
  output logic [1:0]      sram_oe,
  output logic [1:0]      sram_we
);

  localparam int ACC = (WAIT_CYC < 1) ? 1 : WAIT_CYC;
  localparam logic [3:0] LAST = 4'(ACC - 1);

  typedef enum logic [1:0] {
    W_IDLE, W_SETUP, W_ACC, W_HOLD
  } w_st_t;

  typedef enum logic [1:0] {
    R_IDLE, R_SETUP, R_ACC, R_DONE
  } r_st_t;

  w_st_t w_st, w_nx;
  r_st_t r_st, r_nx;

  logic [3:0]    w_cnt, r_cnt;
  logic          w_bank, r_bank;
  logic [DW-1:0] w_data;
  logic [DW-1:0] rd_q;
  logic [AW-1:0] ab0, ab1;
  logic          sel, swap_pend;
  logic          w_go, r_go;
  logic          both_idle, swap_now;
  logic          w_on, r_on;

  // Accept and swap qualifiers; a swap request beats a new access.
  always_comb begin
    both_idle = (w_st == W_IDLE) && (r_st == R_IDLE);
    swap_now  = swap_pend && both_idle;
    w_go = (w_st == W_IDLE) && bus.wr_req
        && !swap_pend && !bus.swap_req;
    r_go = (r_st == R_IDLE) && bus.rd_req
        && !swap_pend && !bus.swap_req;
  end

  // Write channel next state.
  always_comb begin
    w_nx = w_st;
    unique case (w_st)
      W_IDLE:  if (w_go) w_nx = W_SETUP;
      W_SETUP: w_nx = W_ACC;
      W_ACC:   if (w_cnt == LAST) w_nx = W_HOLD;
      W_HOLD:  w_nx = W_IDLE;
      default: w_nx = W_IDLE;
    endcase
  end

  // Read channel next state.
  always_comb begin
    r_nx = r_st;
    unique case (r_st)
      R_IDLE:  if (r_go) r_nx = R_SETUP;
      R_SETUP: r_nx = R_ACC;
      R_ACC:   if (r_cnt == LAST) r_nx = R_DONE;
      R_DONE:  r_nx = R_IDLE;
      default: r_nx = R_IDLE;
    endcase
  end

  // State registers and wait-state counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_st  <= W_IDLE;
      r_st  <= R_IDLE;
      w_cnt <= '0;
      r_cnt <= '0;
    end else begin
      w_st  <= w_nx;
      r_st  <= r_nx;
      w_cnt <= (w_st == W_ACC) ? w_cnt + 4'd1 : '0;
      r_cnt <= (r_st == R_ACC) ? r_cnt + 4'd1 : '0;
    end
  end

  // Bank latching on accept, read capture and bank swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_bank    <= 1'b0;
      r_bank    <= 1'b0;
      w_data    <= '0;
      rd_q      <= '0;
      ab0       <= '0;
      ab1       <= '0;
      sel       <= 1'b0;
      swap_pend <= 1'b0;
    end else begin
      if (w_go) begin
        w_bank <= sel;
        w_data <= bus.wr_data;
        if (sel) ab1 <= bus.wr_addr;
        else     ab0 <= bus.wr_addr;
      end
      if (r_go) begin
        r_bank <= !sel;
        if (sel) ab0 <= bus.rd_addr;
        else     ab1 <= bus.rd_addr;
      end
      if (r_st == R_ACC && r_cnt == LAST)
        rd_q <= r_bank ? sram_db[2*DW-1:DW]
                       : sram_db[DW-1:0];
      if (swap_now) sel <= !sel;
      if (swap_pend) swap_pend <= !both_idle;
      else           swap_pend <= bus.swap_req;
    end
  end

  // Per-bank strobes decoded from channel state and latched bank.
  always_comb begin
    w_on = (w_st != W_IDLE);
    r_on = (r_st == R_SETUP) || (r_st == R_ACC);
    sram_ce[0] = !((w_on && !w_bank) || (r_on && !r_bank));
    sram_ce[1] = !((w_on && w_bank) || (r_on && r_bank));
    sram_we[0] = !((w_st == W_ACC) && !w_bank);
    sram_we[1] = !((w_st == W_ACC) && w_bank);
    sram_oe[0] = !((r_st == R_ACC) && !r_bank);
    sram_oe[1] = !((r_st == R_ACC) && r_bank);
  end

  assign sram_ab = {ab1, ab0};

  assign sram_db[DW-1:0] =
    (w_on && !w_bank) ? w_data : {DW{1'bz}};
  assign sram_db[2*DW-1:DW] =
    (w_on && w_bank) ? w_data : {DW{1'bz}};

  assign bus.wr_ack    = (w_st == W_HOLD);
  assign bus.rd_valid  = (r_st == R_DONE);
  assign bus.rd_data   = rd_q;
  assign bus.swap_done = swap_now;
  assign bus.bank_sel  = sel;

endmodule

// File: tb/tb_sram_pingpong_ctrl.sv
// Bench for sram_pingpong_ctrl: two instances (WAIT_CYC 2 and 0)
// with behavioural SRAM banks and a read-data scoreboard.
module tb_sram_pingpong_ctrl;

  localparam int AW = 20;
  localparam int DW = 16;

  logic clk;
  logic rst;

  logic          wr_req[2];
  logic [AW-1:0] wr_addr[2];
  logic [DW-1:0] wr_data[2];
  logic          rd_req[2];
  logic [AW-1:0] rd_addr[2];
  logic          swap_req[2];

  logic          wr_ack[2];
  logic          rd_valid[2];
  logic [DW-1:0] rd_data[2];
  logic          swap_done[2];
  logic          bank_sel[2];

  logic [2*AW-1:0] ab[2];
  logic [1:0]      ce[2];
  logic [1:0]      oe[2];
  logic [1:0]      we[2];

  logic [DW-1:0] mem [2][2][256];
  logic [DW-1:0] wm  [2][2][256];
  logic          expbank[2];
  logic [DW-1:0] rq0[$];
  logic [DW-1:0] rq1[$];

  int n_tot = 0;
  int n_bad = 0;
  int viol  = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    wire [2*DW-1:0] db;

    sram_pingpong_ctrl_if #(.AW(AW), .DW(DW)) ifc ();

    assign ifc.wr_req   = wr_req[k];
    assign ifc.wr_addr  = wr_addr[k];
    assign ifc.wr_data  = wr_data[k];
    assign ifc.rd_req   = rd_req[k];
    assign ifc.rd_addr  = rd_addr[k];
    assign ifc.swap_req = swap_req[k];
    assign wr_ack[k]    = ifc.wr_ack;
    assign rd_valid[k]  = ifc.rd_valid;
    assign rd_data[k]   = ifc.rd_data;
    assign swap_done[k] = ifc.swap_done;
    assign bank_sel[k]  = ifc.bank_sel;

    sram_pingpong_ctrl #(
      .AW(AW), .DW(DW), .WAIT_CYC(k == 0 ? 2 : 0)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (ifc),
      .sram_ab (ab[k]),
      .sram_db (db),
      .sram_ce (ce[k]),
      .sram_oe (oe[k]),
      .sram_we (we[k])
    );

    for (genvar b = 0; b < 2; b++) begin : g_bank
      assign db[b*DW +: DW] =
        (!ce[k][b] && !oe[k][b])
          ? mem[k][b][ab[k][b*AW +: 8]]
          : {DW{1'bz}};

      always @(posedge clk)
        if (!ce[k][b] && !we[k][b])
          mem[k][b][ab[k][b*AW +: 8]] <= db[b*DW +: DW];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=done");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic [DW-1:0] v);
    if (k == 0) rq0.push_back(v);
    else        rq1.push_back(v);
  endtask

  // Scoreboard pop on every rd_valid, plus bus isolation watch.
  always @(negedge clk) begin
    if (rd_valid[0]) begin
      if (rq0.size() == 0) chk("rd_unexp0", 1, 0);
      else chk("rd_data0", rd_data[0], rq0.pop_front());
    end
    if (rd_valid[1]) begin
      if (rq1.size() == 0) chk("rd_unexp1", 1, 0);
      else chk("rd_data1", rd_data[1], rq1.pop_front());
    end
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 2; b++)
        if (!oe[k][b] && !we[k][b]) viol++;
  end

  task automatic wr_once(input int k,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d,
                         input int swap_at,
                         output int lat,
                         output int wl0, output int wl1,
                         output int cl0, output int cl1,
                         output logic sd);
    bit done;
    wr_addr[k] = a;
    wr_data[k] = d;
    wr_req[k]  = 1'b1;
    wm[k][int'(expbank[k])][a[7:0]] = d;
    @(posedge clk); #1;
    wr_req[k] = 1'b0;
    lat = 1; wl0 = 0; wl1 = 0; cl0 = 0; cl1 = 0;
    sd = 1'b0; done = 1'b0;
    swap_req[k] = (swap_at == 1);
    while (!done) begin
      @(negedge clk);
      if (!we[k][0]) wl0++;
      if (!we[k][1]) wl1++;
      if (!ce[k][0]) cl0++;
      if (!ce[k][1]) cl1++;
      if (wr_ack[k]) begin
        sd = swap_done[k];
        done = 1'b1;
      end else if (lat >= 20) begin
        chk("wr_timeout", 1, 0);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        lat++;
        swap_req[k] = (lat == swap_at);
      end
    end
    swap_req[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd_once(input int k,
                         input logic [AW-1:0] a,
                         output int lat,
                         output int ol0, output int ol1);
    bit done;
    rd_addr[k] = a;
    rd_req[k]  = 1'b1;
    push(k, wm[k][int'(!expbank[k])][a[7:0]]);
    @(posedge clk); #1;
    rd_req[k] = 1'b0;
    lat = 1; ol0 = 0; ol1 = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!oe[k][0]) ol0++;
      if (!oe[k][1]) ol1++;
      if (rd_valid[k]) done = 1'b1;
      else if (lat >= 20) begin
        chk("rd_timeout", 1, 0);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic swap_once(input int k, output int n);
    bit done;
    swap_req[k] = 1'b1;
    @(posedge clk); #1;
    swap_req[k] = 1'b0;
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (swap_done[k]) done = 1'b1;
      else if (n >= 20) begin
        chk("swap_timeout", 1, 0);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    @(posedge clk); #1;
    expbank[k] = !expbank[k];
    chk("bank_sel", bank_sel[k], expbank[k]);
  endtask

  task automatic b2b(input int k, input int nw, input int nr,
                     input logic [AW-1:0] base);
    int wi, ri, t, lw, lr, gap;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    gap = ((k == 0) ? 2 : 1) + 3;
    wi = 0; ri = 0; t = 0; lw = -1; lr = -1;
    if (nw > 0) begin
      d = 16'($urandom);
      wr_addr[k] = base;
      wr_data[k] = d;
      wm[k][int'(expbank[k])][base[7:0]] = d;
      wr_req[k] = 1'b1;
    end
    if (nr > 0) begin
      rd_addr[k] = base;
      push(k, wm[k][int'(!expbank[k])][base[7:0]]);
      rd_req[k] = 1'b1;
    end
    while ((wi < nw || ri < nr) && t < 400) begin
      @(negedge clk);
      t++;
      if (wr_ack[k]) begin
        if (lw >= 0) chk("wr_gap", t - lw, gap);
        lw = t;
        wi++;
        if (wi < nw) begin
          a = base + AW'(wi);
          d = 16'($urandom);
          wr_addr[k] = a;
          wr_data[k] = d;
          wm[k][int'(expbank[k])][a[7:0]] = d;
        end else wr_req[k] = 1'b0;
      end
      if (rd_valid[k]) begin
        if (lr >= 0) chk("rd_gap", t - lr, gap);
        lr = t;
        ri++;
        if (ri < nr) begin
          a = base + AW'(ri);
          rd_addr[k] = a;
          push(k, wm[k][int'(!expbank[k])][a[7:0]]);
        end else rd_req[k] = 1'b0;
      end
    end
    if (t >= 400) chk("b2b_timeout", 1, 0);
    wr_req[k] = 1'b0;
    rd_req[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  int lat, l0, l1, c0, c1, n, acks;
  logic sd;

  initial begin
    for (int k = 0; k < 2; k++) begin
      wr_req[k]   = 1'b0;
      wr_addr[k]  = '0;
      wr_data[k]  = '0;
      rd_req[k]   = 1'b0;
      rd_addr[k]  = '0;
      swap_req[k] = 1'b0;
      expbank[k]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ce", ce[0], 2'b11);
    chk("rst_oe", oe[0], 2'b11);
    chk("rst_we", we[0], 2'b11);
    chk("rst_bank", bank_sel[0], 0);
    chk("rst_ack", wr_ack[0], 0);
    chk("rst_rv", rd_valid[0], 0);
    chk("rst_sd", swap_done[0], 0);
    chk("rst_rd", rd_data[0], 0);
    chk("rst_ab", ab[0], 0);
    @(posedge clk); #1;

    wr_once(0, 20'h00010, 16'hBEEF, 0,
            lat, l0, l1, c0, c1, sd);
    chk("w_lat", lat, 4);
    chk("w_we0", l0, 2);
    chk("w_we1", l1, 0);
    chk("w_ce0", c0, 4);
    chk("w_ce1", c1, 0);

    swap_once(0, n);
    chk("swap_lat", n, 0);
    rd_once(0, 20'h00010, lat, l0, l1);
    chk("r_lat", lat, 4);
    chk("r_oe0", l0, 2);
    chk("r_oe1", l1, 0);

    wr_once(0, 20'h00020, 16'h5A5A, 2,
            lat, l0, l1, c0, c1, sd);
    chk("ws_lat", lat, 4);
    chk("ws_we1", l1, 2);
    chk("ws_we0", l0, 0);
    chk("ws_sd_ack", sd, 0);
    @(negedge clk);
    chk("ws_sd_next", swap_done[0], 1);
    @(posedge clk); #1;
    expbank[0] = !expbank[0];
    chk("ws_bank", bank_sel[0], expbank[0]);
    rd_once(0, 20'h00020, lat, l0, l1);
    chk("ws_rd_oe1", l1, 2);

    swap_req[0] = 1'b1;
    wr_addr[0]  = 20'h00030;
    wr_req[0]   = 1'b1;
    @(posedge clk); #1;
    swap_req[0] = 1'b0;
    @(negedge clk);
    chk("win_sd", swap_done[0], 1);
    chk("win_ce", ce[0], 2'b11);
    wr_req[0] = 1'b0;
    @(posedge clk); #1;
    expbank[0] = !expbank[0];
    chk("win_bank", bank_sel[0], expbank[0]);

    b2b(0, 8, 0, 20'h00100);
    swap_once(0, n);
    b2b(0, 8, 8, 20'h00100);

    swap_once(0, n);
    wr_addr[0] = 20'h00040;
    wr_data[0] = 16'h7777;
    wr_req[0]  = 1'b1;
    @(posedge clk); #1;
    wr_req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expbank[0] = 1'b0;
    expbank[1] = 1'b0;
    @(negedge clk);
    chk("ra_ce", ce[0], 2'b11);
    chk("ra_oe", oe[0], 2'b11);
    chk("ra_we", we[0], 2'b11);
    chk("ra_bank", bank_sel[0], 0);
    chk("ra_ab", ab[0], 0);
    acks = 0;
    repeat (6) begin
      if (wr_ack[0]) acks++;
      @(negedge clk);
    end
    chk("ra_noack", acks, 0);
    @(posedge clk); #1;

    wr_once(1, 20'h00033, 16'h1234, 0,
            lat, l0, l1, c0, c1, sd);
    chk("z_w_lat", lat, 3);
    chk("z_we0", l0, 1);
    swap_once(1, n);
    rd_once(1, 20'h00033, lat, l0, l1);
    chk("z_r_lat", lat, 3);
    chk("z_oe0", l0, 1);
    b2b(1, 4, 0, 20'h00200);
    swap_once(1, n);
    b2b(1, 4, 4, 20'h00200);

    repeat (5) @(posedge clk);
    chk("bus_iso", viol, 0);
    chk("sb_empty", rq0.size() + rq1.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
